// File: rtl/adder_ramp.sv
// adder_ramp: armed saturating ramp generator with hold, completion pulse and ramp counter
module adder_ramp #(
  parameter logic [4:0] TOP   = 5'b11111,
  parameter logic [4:0] START = 5'b00000
) (
  input  logic       Tick,
  input  logic       Reset,
  input  logic [4:0] In,
  input  logic [2:0] Step,
  input  logic       Hold,
  output logic [4:0] Out,
  output logic       state,
  output logic       Done,
  output logic [7:0] Ramps
);
  typedef enum logic [1:0] {IDLE, RAMP, FINISH} fsm_t;
  fsm_t fsm;
  logic [5:0] sum;
  assign sum = {1'b0, Out} + {3'b000, (Step == 3'd0) ? 3'd1 : Step};
  always_ff @(posedge Tick) begin
    if (Reset) begin
      fsm   <= IDLE;
      Out   <= 5'd0;
      state <= 1'b0;
      Done  <= 1'b0;
      Ramps <= 8'd0;
    end else begin
      case (fsm)
        IDLE:
          if (In == START) begin
            Out   <= In;
            state <= 1'b1;
            fsm   <= RAMP;
          end
        RAMP:
          if (!Hold) begin
            Out  <= (sum >= {1'b0, TOP}) ? TOP : sum[4:0];
            Done <= sum >= {1'b0, TOP};
            fsm  <= (sum >= {1'b0, TOP}) ? FINISH : RAMP;
          end
        FINISH: begin
          Done  <= 1'b0;
          state <= 1'b0;
          Ramps <= (Ramps == 8'd255) ? Ramps : Ramps + 8'd1;
          fsm   <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adder_ramp.md
ADDER_RAMP -- requirements
Module: adder_ramp

Interface
REQ-001 Parameter TOP, default 5'b11111, ramp ceiling; Out saturates here.
REQ-002 Parameter START, default 5'b00000, In value that arms a ramp.
REQ-003 Tick  input  1  single clock; all state changes on posedge Tick.
REQ-004 Reset  input  1  synchronous, active-high reset; sampled on posedge Tick.
REQ-005 In  input  5  trigger/load value, sampled only in IDLE.
REQ-006 Step  input  3  increment per Tick in RAMP; Step==0 SHALL be treated as 1.
REQ-007 Hold  input  1  pause; while high in RAMP, Out and FSM hold.
REQ-008 Out  output  5  registered ramp value.
REQ-009 state  output  1  registered; 1 in RAMP or FINISH, 0 in IDLE.
REQ-010 Done  output  1  registered one-Tick pulse on ramp completion.
REQ-011 Ramps  output  8  registered count of completed ramps, saturating at 255.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RAMP, FINISH.
REQ-013 IDLE: if In==START, Out<=In, state<=1, next RAMP; else Out, state hold, stay IDLE.
REQ-014 IDLE: In SHALL be ignored once the FSM leaves IDLE, until it returns.
REQ-015 RAMP, Hold==1: Out, state, Done, Ramps unchanged; stay RAMP.
REQ-016 RAMP, Hold==0: eff = (Step==0 ? 1 : Step); sum = Out + eff computed at 6 bits, no wrap.
REQ-017 RAMP, Hold==0, sum < TOP: Out<=sum[4:0]; stay RAMP.
REQ-018 RAMP, Hold==0, sum >= TOP: Out<=TOP, Done<=1, next FINISH (no overshoot, no wrap past TOP).
REQ-019 RAMP entered with Out>=TOP (START>=TOP): first non-held Tick SHALL apply REQ-018.
REQ-020 FINISH: Done<=0, Out holds TOP, Ramps<=Ramps+1 unless already 255, state<=0, next IDLE; Hold SHALL be ignored in FINISH.
REQ-021 Done SHALL be high for exactly one Tick per completed ramp, the Tick in which FSM is in FINISH.
REQ-022 Back-to-back ramps: if In==START on the first IDLE Tick after FINISH, a new ramp SHALL arm that Tick.
REQ-023 Out SHALL change only in IDLE (load) or RAMP (increment/saturate); never from In outside IDLE.
REQ-024 Latency: In==START to state==1 is one Tick; with Step=1, START=0, TOP=31, Done asserts 31 Ticks after state rises.

Reset
REQ-025 Reset==1 at posedge Tick SHALL force Out=5'b00000, state=0, Done=0, Ramps=0, FSM=IDLE.
REQ-026 Reset SHALL take priority over Hold, In and every FSM transition, including mid-RAMP and in FINISH.
REQ-027 Reset during FINISH SHALL NOT increment Ramps.
REQ-028 First Tick after Reset deasserts SHALL evaluate IDLE rules per REQ-013.

Verification
REQ-029 Reset, In=0, Step=1, Hold=0 -> state=1 next Tick; Out 0,1,...,30,31; Done one Tick high with Out=31; then state=0, Ramps=1.
REQ-030 In=0, Step=7 -> Out 0,7,14,21,28,31 (saturate, not 35/3); Done once; Ramps increments once.
REQ-031 Step=0 -> behaves identically to Step=1 (Out increments by 1 per Tick).
REQ-032 Mid-ramp Out=10, Hold=1 for 5 Ticks -> Out stays 10, Done=0; Hold=0 -> Out 11 next Tick.
REQ-033 Reset asserted at Out=20 in RAMP -> Out=0, state=0, Done=0, Ramps=0 next Tick; In=5 afterwards -> stays IDLE.
REQ-034 In held at 0 continuously for 300 ramps -> Done pulses once per ramp, back-to-back arm per REQ-022, Ramps saturates at 255.
